id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline, with integrated load-use hazard detection.
- Captures decoded control, operands, immediate and register indices from ID, and presents them to EX.
- Its Rs/Rt/Rd outputs are the ID/EX.Rs and ID/EX.Rt operands of the forwarding unit, and feed the RegDst mux.
- Detects load-use hazards, stalls PC and IF/ID, inserts a bubble into EX, and keeps saturating bubble and flush counters.

Parameters:
DATA_W, 32, operand/immediate width
CNT_W, 16, width of bubble/flush counters

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous active-high reset
flush_i  input  1  branch/jump taken in ID; squash the instruction entering EX
reg_write_i  input  1  control from decoder
mem_to_reg_i  input  1  control
mem_read_i  input  1  control
mem_write_i  input  1  control
alu_src_i  input  1  control
alu_op_i  input  2  control
reg_dst_i  input  1  control
uses_rt_i  input  1  ID instruction reads Rt as a source (R-type, sw, beq)
data1_i  input  DATA_W  register file read port 1
data2_i  input  DATA_W  register file read port 2
imm_i  input  DATA_W  sign-extended immediate
rs_i  input  5  IF/ID Rs
rt_i  input  5  IF/ID Rt
rd_i  input  5  IF/ID Rd
reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, alu_src_o, reg_dst_o  output  1 each  registered controls
alu_op_o  output  2  registered
data1_o, data2_o, imm_o  output  DATA_W  registered
rs_o, rt_o, rd_o  output  5  registered; rs_o/rt_o go to the forwarding unit
stall_o  output  1  hold PC and IF/ID this cycle
bubble_cnt_o  output  CNT_W  bubbles inserted due to load-use
flush_cnt_o  output  CNT_W  bubbles inserted due to flush_i

Behaviour:
- Clock and reset: one clock clk_i; rst_i is synchronous, active-high.
- Reset: every registered output and both counters become 0, so stall_o evaluates to 0.
- stall_o is combinational from registered state and ID inputs:
  - stall_o = mem_read_o & (rt_o != 0) & ((rt_o == rs_i) | (uses_rt_i & (rt_o == rt_i))).
  - No dependency on the clock edge within a cycle.
- Per-edge priority when rst_i = 0:
  - flush_i = 1: load bubble; flush_cnt_o += 1 (saturating).
  - else stall_o = 1: load bubble; bubble_cnt_o += 1 (saturating).
  - else: load all *_i fields into the matching *_o (latency 1 cycle).
- Bubble: all control outputs, data1_o, data2_o, imm_o, rs_o, rt_o and rd_o become 0.
  - A zero Rs/Rt guarantees no forwarding match.
- flush_i and stall_o both 1: counts as a flush only; stall_o is still driven high that cycle, because IF/ID is held or flushed by its own logic.
- A load-use hazard produces exactly one stall cycle: the bubble clears mem_read_o, so stall_o drops on the next cycle and the held ID instruction then loads.
- Back-to-back loads (lw r1; lw r2,0(r1)): one stall. The second lw then becomes a new hazard source for the instruction behind it.
- Destination register r0 never causes a stall.
- A store whose Rt matches a preceding load's Rt stalls, because uses_rt_i = 1.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall: outputs and counters clear on that edge; stall_o is 0 on the following cycle.
- No X propagation: every register has a defined reset value.

Test Plan:
- Reset: rst_i = 1 for 2 cycles with random inputs -> all outputs 0, stall_o = 0, both counters 0.
- Pass-through: rs_i = 3, rt_i = 4, rd_i = 5, data1_i = 0x11, reg_write_i = 1, alu_op_i = 2'b10, mem_read_o = 0 -> next cycle rs_o = 3, rt_o = 4, rd_o = 5, data1_o = 0x11, reg_write_o = 1, alu_op_o = 2'b10; stall_o = 0.
- Load-use:
  - Load lw with rt_i = 8, mem_read_i = 1, then present add with rs_i = 8.
  - Required: stall_o = 1 for exactly one cycle, then a bubble (all outputs 0, bubble_cnt_o = 1).
  - Required: on the following cycle add loads, with rs_o = 8.
- No false stall:
  - lw with rt = 0 followed by a reader of r0 -> stall_o = 0.
  - lw rt = 9 followed by addi using rt_i = 9 and uses_rt_i = 0 -> stall_o = 0.
- Flush priority: hazard condition active and flush_i = 1 on the same edge -> bubble loaded, flush_cnt_o = 1, bubble_cnt_o unchanged.
- Saturation: with CNT_W = 4, force 17 load-use stalls -> bubble_cnt_o = 15 and holds; then rst_i -> 0.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded fields from ID, registered fields to EX,
// plus the hazard stall and bubble/flush counters.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              flush_i;
    logic              reg_write_i;
    logic              mem_to_reg_i;
    logic              mem_read_i;
    logic              mem_write_i;
    logic              alu_src_i;
    logic [1:0]        alu_op_i;
    logic              reg_dst_i;
    logic              uses_rt_i;
    logic [DATA_W-1:0] data1_i;
    logic [DATA_W-1:0] data2_i;
    logic [DATA_W-1:0] imm_i;
    logic [4:0]        rs_i;
    logic [4:0]        rt_i;
    logic [4:0]        rd_i;

    logic              reg_write_o;
    logic              mem_to_reg_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic              alu_src_o;
    logic              reg_dst_o;
    logic [1:0]        alu_op_o;
    logic [DATA_W-1:0] data1_o;
    logic [DATA_W-1:0] data2_o;
    logic [DATA_W-1:0] imm_o;
    logic [4:0]        rs_o;
    logic [4:0]        rt_o;
    logic [4:0]        rd_o;
    logic              stall_o;
    logic [CNT_W-1:0]  bubble_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output flush_i, reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i,
               alu_src_i, alu_op_i, reg_dst_i, uses_rt_i, data1_i, data2_i,
               imm_i, rs_i, rt_i, rd_i,
        input  reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, alu_src_o,
               reg_dst_o, alu_op_o, data1_o, data2_o, imm_o, rs_o, rt_o, rd_o,
               stall_o, bubble_cnt_o, flush_cnt_o
    );

    modport slave (
        input  flush_i, reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i,
               alu_src_i, alu_op_i, reg_dst_i, uses_rt_i, data1_i, data2_i,
               imm_i, rs_i, rt_i, rd_i,
        output reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, alu_src_o,
               reg_dst_o, alu_op_o, data1_o, data2_o, imm_o, rs_o, rt_o, rd_o,
               stall_o, bubble_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and saturating bubble/flush counters.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    id_ex_stage_if.slave bus
);
    logic              reg_write_r, mem_to_reg_r, mem_read_r, mem_write_r;
    logic              alu_src_r, reg_dst_r;
    logic [1:0]        alu_op_r;
    logic [DATA_W-1:0] data1_r, data2_r, imm_r;
    logic [4:0]        rs_r, rt_r, rd_r;
    logic [CNT_W-1:0]  bubble_cnt_r, flush_cnt_r;
    logic              stall_s;
    logic              bubble_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1'b1);
        end
        return r;
    endfunction

    // Load-use hazard: the load now in EX writes a register the ID instruction reads.
    always_comb begin
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        if (mem_read_r && (rt_r != 5'd0)) begin
            stall_s = (rt_r == bus.rs_i) || (bus.uses_rt_i && (rt_r == bus.rt_i));
        end else begin
            stall_s = 1'b0;
        end
        bubble_s = bus.flush_i || stall_s;
    end

    // Pipeline register: a bubble zeroes Rs/Rt too so forwarding never matches it.
    always_ff @(posedge clk_i) begin
        if (rst_i || bubble_s) begin
            reg_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            alu_src_r    <= 1'b0;
            reg_dst_r    <= 1'b0;
            alu_op_r     <= 2'b00;
            data1_r      <= {DATA_W{1'b0}};
            data2_r      <= {DATA_W{1'b0}};
            imm_r        <= {DATA_W{1'b0}};
            rs_r         <= 5'd0;
            rt_r         <= 5'd0;
            rd_r         <= 5'd0;
        end else begin
            reg_write_r  <= bus.reg_write_i;
            mem_to_reg_r <= bus.mem_to_reg_i;
            mem_read_r   <= bus.mem_read_i;
            mem_write_r  <= bus.mem_write_i;
            alu_src_r    <= bus.alu_src_i;
            reg_dst_r    <= bus.reg_dst_i;
            alu_op_r     <= bus.alu_op_i;
            data1_r      <= bus.data1_i;
            data2_r      <= bus.data2_i;
            imm_r        <= bus.imm_i;
            rs_r         <= bus.rs_i;
            rt_r         <= bus.rt_i;
            rd_r         <= bus.rd_i;
        end
    end

    // Counters: a flush coinciding with a hazard is counted only as a flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
        end else if (bus.flush_i) begin
            bubble_cnt_r <= bubble_cnt_r;
            flush_cnt_r  <= sat_inc(flush_cnt_r);
        end else if (stall_s) begin
            bubble_cnt_r <= sat_inc(bubble_cnt_r);
            flush_cnt_r  <= flush_cnt_r;
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
            flush_cnt_r  <= flush_cnt_r;
        end
    end

    assign bus.reg_write_o  = reg_write_r;
    assign bus.mem_to_reg_o = mem_to_reg_r;
    assign bus.mem_read_o   = mem_read_r;
    assign bus.mem_write_o  = mem_write_r;
    assign bus.alu_src_o    = alu_src_r;
    assign bus.reg_dst_o    = reg_dst_r;
    assign bus.alu_op_o     = alu_op_r;
    assign bus.data1_o      = data1_r;
    assign bus.data2_o      = data2_r;
    assign bus.imm_o        = imm_r;
    assign bus.rs_o         = rs_r;
    assign bus.rt_o         = rt_r;
    assign bus.rd_o         = rd_r;
    assign bus.stall_o      = stall_s;
    assign bus.bubble_cnt_o = bubble_cnt_r;
    assign bus.flush_cnt_o  = flush_cnt_r;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX-side state is queued when
// each ID instruction is driven and compared one edge later.
module tb_id_ex_stage;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic              rst;
        logic              flush;
        logic              rw, mtr, mr, mw, as, rdst;
        logic [1:0]        op;
        logic              uses_rt;
        logic [DATA_W-1:0] d1, d2, imm;
        logic [4:0]        rs, rt, rd;
    } stim_t;

    typedef struct packed {
        logic              rw, mtr, mr, mw, as, rdst;
        logic [1:0]        op;
        logic [DATA_W-1:0] d1, d2, imm;
        logic [4:0]        rs, rt, rd;
        logic [CNT_W-1:0]  bc, fc;
    } exp_t;

    logic  clk_i = 1'b0;
    logic  rst_i = 1'b1;
    int    checks = 0;
    int    failures = 0;
    exp_t  exp_q[$];
    exp_t  cur;
    bit    model_valid = 1'b0;

    id_ex_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
        return (v == 4'hF) ? v : v + 4'h1;
    endfunction

    function automatic logic model_stall(input exp_t c, input stim_t s);
        return c.mr && (c.rt != 5'd0) && ((c.rt == s.rs) || (s.uses_rt && (c.rt == s.rt)));
    endfunction

    function automatic exp_t model_next(input exp_t c, input stim_t s, input logic stall);
        exp_t n;
        n = '0;
        if (s.rst) begin
            n = '0;
        end else if (s.flush) begin
            n.bc = c.bc;
            n.fc = sat(c.fc);
        end else if (stall) begin
            n.bc = sat(c.bc);
            n.fc = c.fc;
        end else begin
            n.rw = s.rw; n.mtr = s.mtr; n.mr = s.mr; n.mw = s.mw;
            n.as = s.as; n.rdst = s.rdst; n.op = s.op;
            n.d1 = s.d1; n.d2 = s.d2; n.imm = s.imm;
            n.rs = s.rs; n.rt = s.rt; n.rd = s.rd;
            n.bc = c.bc; n.fc = c.fc;
        end
        return n;
    endfunction

    function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                 input logic mr, input logic uses_rt);
        stim_t s;
        s = '0;
        s.rs = rs; s.rt = rt; s.rd = rd;
        s.mr = mr; s.mtr = mr; s.rw = 1'b1; s.as = mr;
        s.uses_rt = uses_rt; s.rdst = ~mr;
        s.op = mr ? 2'b00 : 2'b10;
        s.d1 = $urandom; s.d2 = $urandom; s.imm = $urandom;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        rst_i            = s.rst;
        bus.flush_i      = s.flush;
        bus.reg_write_i  = s.rw;
        bus.mem_to_reg_i = s.mtr;
        bus.mem_read_i   = s.mr;
        bus.mem_write_i  = s.mw;
        bus.alu_src_i    = s.as;
        bus.alu_op_i     = s.op;
        bus.reg_dst_i    = s.rdst;
        bus.uses_rt_i    = s.uses_rt;
        bus.data1_i      = s.d1;
        bus.data2_i      = s.d2;
        bus.imm_i        = s.imm;
        bus.rs_i         = s.rs;
        bus.rt_i         = s.rt;
        bus.rd_i         = s.rd;
    endtask

    task automatic compare_out(input string tag, input exp_t e);
        check({tag, "_ctrl"}, {24'd0, bus.reg_write_o, bus.mem_to_reg_o, bus.mem_read_o,
              bus.mem_write_o, bus.alu_src_o, bus.reg_dst_o, bus.alu_op_o},
              {24'd0, e.rw, e.mtr, e.mr, e.mw, e.as, e.rdst, e.op});
        check({tag, "_data1"}, bus.data1_o, e.d1);
        check({tag, "_data2"}, bus.data2_o, e.d2);
        check({tag, "_imm"}, bus.imm_o, e.imm);
        check({tag, "_regs"}, {17'd0, bus.rs_o, bus.rt_o, bus.rd_o}, {17'd0, e.rs, e.rt, e.rd});
        check({tag, "_bcnt"}, {28'd0, bus.bubble_cnt_o}, {28'd0, e.bc});
        check({tag, "_fcnt"}, {28'd0, bus.flush_cnt_o}, {28'd0, e.fc});
    endtask

    // want_stall: -1 = no fixed expectation, 0/1 = stall_o value the scenario demands
    task automatic cycle(input string tag, input stim_t s, input int want_stall);
        logic st;
        exp_t e;
        drive(s);
        #1;
        st = model_valid ? model_stall(cur, s) : 1'b0;
        if (model_valid) check({tag, "_stall"}, {31'd0, bus.stall_o}, {31'd0, st});
        if (want_stall >= 0) check({tag, "_stall_req"}, {31'd0, bus.stall_o}, want_stall[31:0]);
        exp_q.push_back(model_next(cur, s, st));
        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        compare_out(tag, e);
        cur = e;
        model_valid = 1'b1;
    endtask

    initial begin
        stim_t s;
        logic [CNT_W-1:0] bc_before;
        cur = '0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            s = mk(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
            s.flush = 1'($urandom);
            s.rst = 1'b1;
            cycle("reset", s, -1);
        end
        s = '0;
        cycle("post_reset", s, 0);

        // Pass-through
        s = mk(5'd3, 5'd4, 5'd5, 1'b0, 1'b1);
        s.d1 = 32'h11;
        cycle("pass", s, 0);
        check("pass_rs", {27'd0, bus.rs_o}, 32'd3);
        check("pass_rd", {27'd0, bus.rd_o}, 32'd5);
        check("pass_d1", bus.data1_o, 32'h11);
        check("pass_op", {30'd0, bus.alu_op_o}, 32'd2);

        // Load-use: one stall, one bubble, then the add loads
        cycle("lu_lw", mk(5'd2, 5'd8, 5'd0, 1'b1, 1'b0), 0);
        s = mk(5'd8, 5'd7, 5'd9, 1'b0, 1'b1);
        cycle("lu_stall", s, 1);
        check("lu_bubble_rs", {27'd0, bus.rs_o}, 32'd0);
        check("lu_bcnt1", {28'd0, bus.bubble_cnt_o}, 32'd1);
        cycle("lu_add", s, 0);
        check("lu_add_rs", {27'd0, bus.rs_o}, 32'd8);

        // No false stall
        cycle("r0_lw", mk(5'd1, 5'd0, 5'd0, 1'b1, 1'b0), 0);
        cycle("r0_use", mk(5'd0, 5'd0, 5'd2, 1'b0, 1'b1), 0);
        cycle("addi_lw", mk(5'd1, 5'd9, 5'd0, 1'b1, 1'b0), 0);
        cycle("addi_use", mk(5'd1, 5'd9, 5'd0, 1'b0, 1'b0), 0);

        // Store reading the loaded Rt stalls
        cycle("sw_lw", mk(5'd1, 5'd10, 5'd0, 1'b1, 1'b0), 0);
        s = mk(5'd3, 5'd10, 5'd0, 1'b0, 1'b1);
        s.mw = 1'b1; s.rw = 1'b0;
        cycle("sw_stall", s, 1);
        cycle("sw_go", s, 0);

        // Back-to-back loads
        cycle("b2b_lw1", mk(5'd4, 5'd1, 5'd0, 1'b1, 1'b0), 0);
        s = mk(5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        cycle("b2b_stall", s, 1);
        cycle("b2b_lw2", s, 0);
        cycle("b2b_use", mk(5'd2, 5'd3, 5'd6, 1'b0, 1'b1), 1);

        // Flush wins over hazard
        cycle("fl_lw", mk(5'd2, 5'd8, 5'd0, 1'b1, 1'b0), 0);
        bc_before = cur.bc;
        s = mk(5'd8, 5'd3, 5'd4, 1'b0, 1'b1);
        s.flush = 1'b1;
        cycle("fl_both", s, 1);
        check("fl_fcnt1", {28'd0, bus.flush_cnt_o}, 32'd1);
        check("fl_bcnt_same", {28'd0, bus.bubble_cnt_o}, {28'd0, bc_before});

        // Random traffic over a small register range
        for (int i = 0; i < 40; i++) begin
            s = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom));
            s.flush = ($urandom_range(0, 7) == 0);
            cycle("rand", s, -1);
        end

        // Bubble counter saturation
        for (int i = 0; i < 17; i++) begin
            cycle("sat_lw", mk(5'd1, 5'd8, 5'd0, 1'b1, 1'b0), -1);
            cycle("sat_use", mk(5'd8, 5'd2, 5'd3, 1'b0, 1'b0), 1);
        end
        check("sat_bcnt", {28'd0, bus.bubble_cnt_o}, 32'd15);

        // Reset asserted mid-stall
        cycle("rst_lw", mk(5'd1, 5'd8, 5'd0, 1'b1, 1'b0), 0);
        s = mk(5'd8, 5'd2, 5'd3, 1'b0, 1'b0);
        s.rst = 1'b1;
        cycle("rst_stall", s, 1);
        check("rst_bcnt0", {28'd0, bus.bubble_cnt_o}, 32'd0);
        check("rst_fcnt0", {28'd0, bus.flush_cnt_o}, 32'd0);
        s.rst = 1'b0;
        cycle("rst_after", s, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
